// File: rtl/token_pkg.sv
// Shared types for the token window counter: result record, queue depth, FSM states.
package token_pkg;

    // Default window size; the result record is sized for it, so an instance
    // must use a WINDOW no larger than this.
    localparam int TOK_WINDOW = 16;
    localparam int TOK_CNT_W  = $clog2(TOK_WINDOW + 1);
    localparam int TOK_QDEPTH = 2;

    typedef struct packed {
        logic                 partial;
        logic [TOK_CNT_W-1:0] count;
    } tok_result_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } tok_state_t;

endpackage

// File: rtl/token_result_fifo.sv
// Small result FIFO (TOK_QDEPTH entries) between the window counter and its consumer.
// The head is read straight from storage, so outputs never depend on the inputs
// combinationally.
module token_result_fifo
    import token_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  tok_result_t din,
    output tok_result_t head,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = (TOK_QDEPTH > 1) ? $clog2(TOK_QDEPTH) : 1;
    localparam int QC_W  = $clog2(TOK_QDEPTH + 1);
    localparam logic [QC_W-1:0]  QC_ONE  = QC_W'(1);
    localparam logic [QC_W-1:0]  QC_FULL = QC_W'(TOK_QDEPTH);
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(TOK_QDEPTH - 1);

    tok_result_t      mem_q [TOK_QDEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [QC_W-1:0]  cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_END) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full queue only lands when the head leaves in the same cycle.
    always_comb begin
        full    = (cnt_q == QC_FULL);
        empty   = (cnt_q == '0);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head    = mem_q[rd_q];
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TOK_QDEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= ptr_inc(wr_q);
            end
            if (do_pop) rd_q <= ptr_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + QC_ONE;
                2'b01:   cnt_q <= cnt_q - QC_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/token_window_counter.sv
// Counts '1' tokens of a serial stream over windows of WINDOW enabled samples and
// queues each window result behind a valid/ready handshake. A flush closes the
// running window early as a partial result; results that find the queue full are
// counted in a saturating drop counter.
module token_window_counter
    import token_pkg::*;
#(
    parameter int WINDOW = TOK_WINDOW,
    parameter int CNT_W  = $clog2(WINDOW + 1),
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tok,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_partial,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);

    localparam logic [CNT_W-1:0] POS_LAST = CNT_W'(WINDOW - 1);

    tok_state_t        state_q, state_d;
    logic [CNT_W-1:0]  pos_q, pos_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [CNT_W-1:0]  count_now;
    logic              full_close, flush_close, close;
    logic              q_full, q_empty, q_pop;
    tok_result_t       q_din, q_head;

    // Close detection: a full close wins over a flush in the same cycle, and a
    // flush with no samples at all (pos 0, no enable) is ignored.
    always_comb begin
        count_now     = acc_q + CNT_W'(en & tok);
        full_close    = en && (pos_q == POS_LAST);
        flush_close   = flush && !full_close && ((pos_q != '0) || en);
        close         = full_close | flush_close;
        q_din.partial = ~full_close;
        q_din.count   = TOK_CNT_W'(count_now);
        q_pop         = ~q_empty & out_ready;
    end

    // Window position / token accumulator next state.
    always_comb begin
        pos_d = pos_q;
        acc_d = acc_q;
        if (close) begin
            pos_d = '0;
            acc_d = '0;
        end else if (en) begin
            pos_d = pos_q + CNT_W'(1);
            acc_d = count_now;
        end
    end

    // Saturating count of results lost to a full queue with no simultaneous pop.
    always_comb begin
        drop_d = drop_q;
        if (close && q_full && !q_pop && (drop_q != '1))
            drop_d = drop_q + DROP_W'(1);
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_q  <= '0;
            acc_q  <= '0;
            drop_q <= '0;
        end else begin
            pos_q  <= pos_d;
            acc_q  <= acc_d;
            drop_q <= drop_d;
        end
    end

    // FSM state register: IDLE means pos==0, COUNT means a window is in progress.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: leave IDLE on the first sample that does not also close.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en && !close) state_d = S_COUNT;
            S_COUNT: if (close)        state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == S_COUNT);
    end

    token_result_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (close),
        .pop   (q_pop),
        .din   (q_din),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Result outputs come from queue storage only; an empty queue shows zeros.
    always_comb begin
        out_valid   = ~q_empty;
        out_count   = q_empty ? '0 : CNT_W'(q_head.count);
        out_partial = ~q_empty & q_head.partial;
        drop_cnt    = drop_q;
    end

endmodule
